// File: rtl/cpu_run_controller.sv
// CPU run controller: issues the single-cycle Go enable to the instruction
// cycle block. Supports free-run on the periodic tick, turbo (every cycle),
// halt, single-step and a one-address IP breakpoint. Also keeps a saturating
// count of issued instructions.
module cpu_run_controller #(
  parameter int unsigned CNT_MAX = 12500000,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Halt,
  input  logic              Step,
  input  logic              Turbo,
  input  logic              BpEn,
  input  logic [ADDR_W-1:0] BpAddr,
  input  logic [ADDR_W-1:0] Ip,
  output logic              Go,
  output logic              Running,
  output logic              AtBreak,
  output logic [15:0]       StepCount
);

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP,
    S_BRK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  state_t            state;
  state_t            state_next;
  logic              skip;
  logic              skip_next;
  logic              go_next;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              slot;
  logic [ADDR_W-1:0] eff_ip;
  logic              bp_hit;

  // Free-running tick counter: starts at 1 so the first tick is CNT_MAX cycles out
  always_ff @(posedge Clock) begin
    if (Reset)
      cnt <= CNT_W'(1);
    else if (cnt == CNT_LAST)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == '0);
  assign slot = tick | Turbo;

  // A Go high in the slot cycle has not yet reached the IP register, so
  // compare against the address that Go is about to execute past.
  assign eff_ip = Ip + ADDR_W'(Go);
  assign bp_hit = BpEn && (eff_ip == BpAddr) && !skip;

  // State, breakpoint-skip flag and registered Go
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_HALT;
      skip  <= 1'b0;
      Go    <= 1'b0;
    end else begin
      state <= state_next;
      skip  <= skip_next;
      Go    <= go_next;
    end
  end

  // Executed-instruction counter, saturating
  always_ff @(posedge Clock) begin
    if (Reset)
      StepCount <= '0;
    else if (Go && (StepCount != '1))
      StepCount <= StepCount + 16'd1;
  end

  // Next-state and next-Go decision; command priority Halt > Run > Step
  always_comb begin
    state_next = state;
    skip_next  = skip;
    go_next    = 1'b0;
    case (state)
      S_HALT: begin
        if (Halt)
          state_next = S_HALT;
        else if (Run)
          state_next = S_RUN;
        else if (Step)
          state_next = S_STEP;
      end
      S_RUN: begin
        if (Halt) begin
          state_next = S_HALT;
        end else if (slot) begin
          if (bp_hit) begin
            state_next = S_BRK;
          end else begin
            go_next   = 1'b1;
            skip_next = 1'b0;
          end
        end
      end
      S_STEP: begin
        if (Halt) begin
          state_next = S_HALT;
        end else if (slot) begin
          go_next    = 1'b1;
          state_next = S_HALT;
        end
      end
      S_BRK: begin
        if (Halt) begin
          state_next = S_BRK;
        end else if (Run) begin
          state_next = S_RUN;
          skip_next  = 1'b1;
        end else if (Step) begin
          state_next = S_STEP;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    Running = (state == S_RUN);
    AtBreak = (state == S_BRK);
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller with CNT_MAX=3 and a simple CPU IP model
// (Ip increments on each Go, resets to 0). Expected IP values per Go are
// queued when a command is issued and popped when Go is observed.
module tb_cpu_run_controller;

  localparam int unsigned CNT_MAX = 3;
  localparam int unsigned CNT_W   = 24;
  localparam int unsigned ADDR_W  = 8;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Run   = 1'b0;
  logic              Halt  = 1'b0;
  logic              Step  = 1'b0;
  logic              Turbo = 1'b0;
  logic              BpEn  = 1'b0;
  logic [ADDR_W-1:0] BpAddr = '0;
  logic [ADDR_W-1:0] Ip;
  logic              Go;
  logic              Running;
  logic              AtBreak;
  logic [15:0]       StepCount;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cnt_m;
  logic [ADDR_W-1:0] exp_ip_q[$];

  cpu_run_controller #(
    .CNT_MAX(CNT_MAX),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Run      (Run),
    .Halt     (Halt),
    .Step     (Step),
    .Turbo    (Turbo),
    .BpEn     (BpEn),
    .BpAddr   (BpAddr),
    .Ip       (Ip),
    .Go       (Go),
    .Running  (Running),
    .AtBreak  (AtBreak),
    .StepCount(StepCount)
  );

  always #5 Clock = ~Clock;

  // CPU instruction pointer model
  always @(posedge Clock) begin
    if (Reset)
      Ip <= '0;
    else if (Go)
      Ip <= Ip + 8'd1;
  end

  // Reference tick counter model
  always @(posedge Clock) begin
    if (Reset)
      cnt_m <= 1;
    else if (cnt_m == CNT_MAX)
      cnt_m <= 0;
    else
      cnt_m <= cnt_m + 1;
  end

  task automatic step_clk();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Run = 1'b0; Halt = 1'b0; Step = 1'b0;
    step_clk();
    step_clk();
    Reset = 1'b0;
    exp_ip_q.delete();
  endtask

  task automatic test_reset();
    int gos;
    Turbo = 1'b0; BpEn = 1'b0; BpAddr = '0;
    Reset = 1'b1;
    step_clk();
    step_clk();
    total++; if (Go !== 1'b0) $display("FAIL reset_go: got %b want 0", Go); else passed++;
    total++; if (Running !== 1'b0) $display("FAIL reset_running: got %b want 0", Running); else passed++;
    total++; if (AtBreak !== 1'b0) $display("FAIL reset_atbreak: got %b want 0", AtBreak); else passed++;
    total++; if (StepCount !== 16'd0) $display("FAIL reset_stepcount: got %0d want 0", StepCount); else passed++;
    Reset = 1'b0;
    gos = 0;
    repeat (20) begin
      step_clk();
      if (Go === 1'b1) gos++;
    end
    total++; if (gos != 0) $display("FAIL idle_no_go: got %0d pulses want 0", gos); else passed++;
  endtask

  task automatic test_turbo_run();
    logic [ADDR_W-1:0] e;
    do_reset();
    Turbo = 1'b1; BpEn = 1'b0;
    for (int i = 0; i < 10; i++) exp_ip_q.push_back(ADDR_W'(i));
    Run = 1'b1;
    step_clk();
    Run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      total++; if (Go !== 1'b1) $display("FAIL turbo_go[%0d]: got %b want 1", i, Go); else passed++;
      if (Go === 1'b1) begin
        total++;
        if (exp_ip_q.size() == 0) $display("FAIL turbo_ip: unexpected Go, Ip=%0d", Ip);
        else begin
          e = exp_ip_q.pop_front();
          if (Ip !== e) $display("FAIL turbo_ip: got %0d want %0d", Ip, e); else passed++;
        end
      end
      if (i == 9) Halt = 1'b1;
    end
    step_clk();
    Halt = 1'b0;
    total++; if (Go !== 1'b0) $display("FAIL turbo_halt_go: got %b want 0", Go); else passed++;
    total++; if (Running !== 1'b0) $display("FAIL turbo_halt_running: got %b want 0", Running); else passed++;
    total++; if (StepCount !== 16'd10) $display("FAIL turbo_stepcount: got %0d want 10", StepCount); else passed++;
    total++; if (Ip !== 8'd10) $display("FAIL turbo_final_ip: got %0d want 10", Ip); else passed++;
  endtask

  task automatic test_breakpoint();
    logic [ADDR_W-1:0] e;
    int gos;
    int n;
    do_reset();
    Turbo = 1'b1; BpEn = 1'b1; BpAddr = 8'd5;
    for (int i = 0; i < 5; i++) exp_ip_q.push_back(ADDR_W'(i));
    Run = 1'b1;
    step_clk();
    Run = 1'b0;
    gos = 0; n = 0;
    while (AtBreak !== 1'b1 && n < 20) begin
      step_clk();
      n++;
      if (Go === 1'b1) begin
        gos++;
        total++;
        if (exp_ip_q.size() == 0) $display("FAIL bp_ip: unexpected Go, Ip=%0d", Ip);
        else begin
          e = exp_ip_q.pop_front();
          if (Ip !== e) $display("FAIL bp_ip: got %0d want %0d", Ip, e); else passed++;
        end
      end
    end
    total++; if (AtBreak !== 1'b1) $display("FAIL bp_atbreak: got %b want 1 (after %0d cycles)", AtBreak, n); else passed++;
    total++; if (gos != 5) $display("FAIL bp_go_count: got %0d want 5", gos); else passed++;
    total++; if (Ip !== 8'd5) $display("FAIL bp_stop_ip: got %0d want 5", Ip); else passed++;
    total++; if (Running !== 1'b0) $display("FAIL bp_running: got %b want 0", Running); else passed++;
    total++; if (StepCount !== 16'd5) $display("FAIL bp_stepcount: got %0d want 5", StepCount); else passed++;
    // resume: breakpointed instruction executes once, then free-runs
    for (int i = 5; i < 9; i++) exp_ip_q.push_back(ADDR_W'(i));
    Run = 1'b1;
    step_clk();
    Run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      total++; if (Go !== 1'b1) $display("FAIL resume_go[%0d]: got %b want 1", i, Go); else passed++;
      if (Go === 1'b1) begin
        total++;
        if (exp_ip_q.size() == 0) $display("FAIL resume_ip: unexpected Go, Ip=%0d", Ip);
        else begin
          e = exp_ip_q.pop_front();
          if (Ip !== e) $display("FAIL resume_ip: got %0d want %0d", Ip, e); else passed++;
        end
      end
      if (i == 3) Halt = 1'b1;
    end
    step_clk();
    Halt = 1'b0;
    total++; if (Running !== 1'b0) $display("FAIL resume_halt: got %b want 0", Running); else passed++;
  endtask

  task automatic test_step();
    logic [ADDR_W-1:0] e;
    int gos;
    do_reset();
    Turbo = 1'b0; BpEn = 1'b0;
    exp_ip_q.push_back(8'd0);
    Step = 1'b1;
    step_clk();
    Step = 1'b0;
    gos = 0;
    repeat (12) begin
      step_clk();
      if (Go === 1'b1) begin
        gos++;
        // Go is registered from the tick cycle, so it lands when cnt has moved to 1
        total++; if (cnt_m != 1) $display("FAIL step_tick_align: cnt=%0d want 1", cnt_m); else passed++;
        total++;
        if (exp_ip_q.size() == 0) $display("FAIL step_ip: unexpected Go, Ip=%0d", Ip);
        else begin
          e = exp_ip_q.pop_front();
          if (Ip !== e) $display("FAIL step_ip: got %0d want %0d", Ip, e); else passed++;
        end
      end
    end
    total++; if (gos != 1) $display("FAIL step_go_count: got %0d want 1", gos); else passed++;
    total++; if (StepCount !== 16'd1) $display("FAIL step_stepcount: got %0d want 1", StepCount); else passed++;
    total++; if (Running !== 1'b0 || AtBreak !== 1'b0)
      $display("FAIL step_state: got run=%b brk=%b want 0 0", Running, AtBreak); else passed++;
  endtask

  task automatic test_step_from_break();
    logic [ADDR_W-1:0] e;
    int gos;
    int n;
    do_reset();
    Turbo = 1'b1; BpEn = 1'b1; BpAddr = 8'd5;
    Run = 1'b1;
    step_clk();
    Run = 1'b0;
    n = 0;
    while (AtBreak !== 1'b1 && n < 20) begin
      step_clk();
      n++;
    end
    total++; if (AtBreak !== 1'b1) $display("FAIL brkstep_reach: got %b want 1", AtBreak); else passed++;
    Turbo = 1'b0;
    exp_ip_q.push_back(8'd5);
    Step = 1'b1;
    step_clk();
    Step = 1'b0;
    gos = 0;
    repeat (10) begin
      step_clk();
      if (Go === 1'b1) begin
        gos++;
        total++;
        if (exp_ip_q.size() == 0) $display("FAIL brkstep_ip: unexpected Go, Ip=%0d", Ip);
        else begin
          e = exp_ip_q.pop_front();
          if (Ip !== e) $display("FAIL brkstep_ip: got %0d want %0d", Ip, e); else passed++;
        end
      end
    end
    total++; if (gos != 1) $display("FAIL brkstep_go_count: got %0d want 1", gos); else passed++;
    total++; if (Ip !== 8'd6) $display("FAIL brkstep_final_ip: got %0d want 6", Ip); else passed++;
    total++; if (AtBreak !== 1'b0 || Running !== 1'b0)
      $display("FAIL brkstep_state: got run=%b brk=%b want 0 0", Running, AtBreak); else passed++;
  endtask

  task automatic test_cmd_priority();
    int gos;
    do_reset();
    Turbo = 1'b0; BpEn = 1'b0;
    Halt = 1'b1; Run = 1'b1;
    step_clk();
    Halt = 1'b0; Run = 1'b0;
    gos = 0;
    repeat (8) begin
      step_clk();
      if (Go === 1'b1) gos++;
    end
    total++; if (gos != 0) $display("FAIL halt_run_go: got %0d pulses want 0", gos); else passed++;
    total++; if (Running !== 1'b0) $display("FAIL halt_run_state: got %b want 0", Running); else passed++;
    Run = 1'b1; Step = 1'b1;
    step_clk();
    Run = 1'b0; Step = 1'b0;
    total++; if (Running !== 1'b1) $display("FAIL run_step_state: got %b want 1", Running); else passed++;
    Halt = 1'b1;
    step_clk();
    Halt = 1'b0;
    total++; if (Running !== 1'b0) $display("FAIL run_then_halt: got %b want 0", Running); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_reset();
    Turbo = 1'b1; BpEn = 1'b0;
    Run = 1'b1;
    step_clk();
    Run = 1'b0;
    repeat (5) step_clk();
    total++; if (Go !== 1'b1) $display("FAIL midrun_go_before: got %b want 1", Go); else passed++;
    Reset = 1'b1; Turbo = 1'b0;
    step_clk();
    total++; if (Go !== 1'b0) $display("FAIL midrun_reset_go: got %b want 0", Go); else passed++;
    total++; if (Running !== 1'b0) $display("FAIL midrun_reset_running: got %b want 0", Running); else passed++;
    total++; if (StepCount !== 16'd0) $display("FAIL midrun_reset_stepcount: got %0d want 0", StepCount); else passed++;
    Reset = 1'b0;
    // counter restarts at 1: Step here sees ticks at cnt 2,3,0 -> Go on third cycle
    Step = 1'b1;
    step_clk();
    Step = 1'b0;
    n = 0;
    do begin
      step_clk();
      n++;
    end while (Go !== 1'b1 && n < 10);
    total++; if (n != 3) $display("FAIL midrun_tick_restart: Go after %0d cycles want 3", n); else passed++;
  endtask

  initial begin
    test_reset();
    test_turbo_run();
    test_breakpoint();
    test_step();
    test_step_from_break();
    test_cmd_priority();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
